// File: rtl/axi_mem_arbiter_pkg.sv
// Shared types and AXI4 field widths for the fetch/LSU memory-port arbiter.
package axi_mem_arbiter_pkg;

  localparam int unsigned AXI4_LEN_W   = 8;
  localparam int unsigned AXI4_SIZE_W  = 3;
  localparam int unsigned AXI4_BURST_W = 2;
  localparam int unsigned AXI4_RESP_W  = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RD_M0 = 2'd1,
    ARB_RD_M1 = 2'd2,
    ARB_WR_M1 = 2'd3
  } arb_state_e;

  // On a tie, pick the requester that was not served last (last: 0 = M0, 1 = M1).
  function automatic logic [1:0] rr2_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return last ? 2'b01 : 2'b10;
    end
    return req;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker; remembers which read master was granted last.
module arb_rr2
  import axi_mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_q, last_d;

  assign grant = rr2_pick(req, last_q);

  always_comb begin
    last_d = last_q;
    if (update && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  // Resetting to M1 lets M0 win the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4 master port between fetch (M0, read-only) and LSU (M1, read/write),
// granting one whole transaction at a time.
module axi_mem_arbiter
  import axi_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  // M0 read
  input  logic                    m0_arvalid,
  input  logic [ADDR_W-1:0]       m0_araddr,
  input  logic [ID_W-1:0]         m0_arid,
  input  logic [AXI4_LEN_W-1:0]   m0_arlen,
  input  logic [AXI4_SIZE_W-1:0]  m0_arsize,
  input  logic [AXI4_BURST_W-1:0] m0_arburst,
  output logic                    m0_arready,
  output logic                    m0_rvalid,
  output logic [AXI4_RESP_W-1:0]  m0_rresp,
  output logic [DATA_W-1:0]       m0_rdata,
  output logic                    m0_rlast,
  output logic [ID_W-1:0]         m0_rid,
  input  logic                    m0_rready,
  // M1 read
  input  logic                    m1_arvalid,
  input  logic [ADDR_W-1:0]       m1_araddr,
  input  logic [ID_W-1:0]         m1_arid,
  input  logic [AXI4_LEN_W-1:0]   m1_arlen,
  input  logic [AXI4_SIZE_W-1:0]  m1_arsize,
  input  logic [AXI4_BURST_W-1:0] m1_arburst,
  output logic                    m1_arready,
  output logic                    m1_rvalid,
  output logic [AXI4_RESP_W-1:0]  m1_rresp,
  output logic [DATA_W-1:0]       m1_rdata,
  output logic                    m1_rlast,
  output logic [ID_W-1:0]         m1_rid,
  input  logic                    m1_rready,
  // M1 write
  input  logic                    m1_awvalid,
  input  logic [ADDR_W-1:0]       m1_awaddr,
  input  logic [ID_W-1:0]         m1_awid,
  input  logic [AXI4_LEN_W-1:0]   m1_awlen,
  input  logic [AXI4_SIZE_W-1:0]  m1_awsize,
  input  logic [AXI4_BURST_W-1:0] m1_awburst,
  output logic                    m1_awready,
  input  logic                    m1_wvalid,
  input  logic [DATA_W-1:0]       m1_wdata,
  input  logic [DATA_W/8-1:0]     m1_wstrb,
  input  logic                    m1_wlast,
  output logic                    m1_wready,
  output logic                    m1_bvalid,
  output logic [AXI4_RESP_W-1:0]  m1_bresp,
  output logic [ID_W-1:0]         m1_bid,
  input  logic                    m1_bready,
  // SoC side
  output logic                    io_master_arvalid,
  output logic [ADDR_W-1:0]       io_master_araddr,
  output logic [ID_W-1:0]         io_master_arid,
  output logic [AXI4_LEN_W-1:0]   io_master_arlen,
  output logic [AXI4_SIZE_W-1:0]  io_master_arsize,
  output logic [AXI4_BURST_W-1:0] io_master_arburst,
  input  logic                    io_master_arready,
  input  logic                    io_master_rvalid,
  input  logic [AXI4_RESP_W-1:0]  io_master_rresp,
  input  logic [DATA_W-1:0]       io_master_rdata,
  input  logic                    io_master_rlast,
  input  logic [ID_W-1:0]         io_master_rid,
  output logic                    io_master_rready,
  output logic                    io_master_awvalid,
  output logic [ADDR_W-1:0]       io_master_awaddr,
  output logic [ID_W-1:0]         io_master_awid,
  output logic [AXI4_LEN_W-1:0]   io_master_awlen,
  output logic [AXI4_SIZE_W-1:0]  io_master_awsize,
  output logic [AXI4_BURST_W-1:0] io_master_awburst,
  input  logic                    io_master_awready,
  output logic                    io_master_wvalid,
  output logic [DATA_W-1:0]       io_master_wdata,
  output logic [DATA_W/8-1:0]     io_master_wstrb,
  output logic                    io_master_wlast,
  input  logic                    io_master_wready,
  input  logic                    io_master_bvalid,
  input  logic [AXI4_RESP_W-1:0]  io_master_bresp,
  input  logic [ID_W-1:0]         io_master_bid,
  output logic                    io_master_bready
);

  arb_state_e state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [1:0] rd_req, rd_grant;
  logic       rd_update;
  logic       rd_sel_m1;
  logic       sel_arvalid, sel_rready;

  assign rd_req    = {m1_arvalid, m0_arvalid};
  assign rd_sel_m1 = (state_q == ARB_RD_M1);
  assign sel_arvalid = rd_sel_m1 ? m1_arvalid : m0_arvalid;
  assign sel_rready  = rd_sel_m1 ? m1_rready  : m0_rready;

  arb_rr2 u_arb_rr2 (
    .clock  (clock),
    .reset  (reset),
    .req    (rd_req),
    .update (rd_update),
    .grant  (rd_grant)
  );

  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rd_update = 1'b0;

    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arid    = '0;
    io_master_arlen   = '0;
    io_master_arsize  = '0;
    io_master_arburst = '0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = '0;
    io_master_awid    = '0;
    io_master_awlen   = '0;
    io_master_awsize  = '0;
    io_master_awburst = '0;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;

    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rresp   = '0;
    m0_rdata   = '0;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rresp   = '0;
    m1_rdata   = '0;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = '0;
    m1_bid     = '0;

    case (state_q)
      ARB_IDLE: begin
        if (m1_awvalid) begin
          state_d = ARB_WR_M1;
        end else if (rd_grant[0]) begin
          state_d   = ARB_RD_M0;
          rd_update = 1'b1;
        end else if (rd_grant[1]) begin
          state_d   = ARB_RD_M1;
          rd_update = 1'b1;
        end
      end

      ARB_RD_M0, ARB_RD_M1: begin
        io_master_arvalid = sel_arvalid & ~ar_done_q;
        io_master_araddr  = rd_sel_m1 ? m1_araddr  : m0_araddr;
        io_master_arid    = rd_sel_m1 ? m1_arid    : m0_arid;
        io_master_arlen   = rd_sel_m1 ? m1_arlen   : m0_arlen;
        io_master_arsize  = rd_sel_m1 ? m1_arsize  : m0_arsize;
        io_master_arburst = rd_sel_m1 ? m1_arburst : m0_arburst;
        io_master_rready  = sel_rready;
        if (rd_sel_m1) begin
          m1_arready = io_master_arready & ~ar_done_q;
          m1_rvalid  = io_master_rvalid;
          m1_rresp   = io_master_rresp;
          m1_rdata   = io_master_rdata;
          m1_rlast   = io_master_rlast;
          m1_rid     = io_master_rid;
        end else begin
          m0_arready = io_master_arready & ~ar_done_q;
          m0_rvalid  = io_master_rvalid;
          m0_rresp   = io_master_rresp;
          m0_rdata   = io_master_rdata;
          m0_rlast   = io_master_rlast;
          m0_rid     = io_master_rid;
        end
        if (sel_arvalid && !ar_done_q && io_master_arready) begin
          ar_done_d = 1'b1;
        end
        if (io_master_rvalid && sel_rready && io_master_rlast) begin
          state_d   = ARB_IDLE;
          ar_done_d = 1'b0;
        end
      end

      ARB_WR_M1: begin
        // AW and W progress independently; each is closed off once it has handshaken.
        io_master_awvalid = m1_awvalid & ~aw_done_q;
        io_master_awaddr  = m1_awaddr;
        io_master_awid    = m1_awid;
        io_master_awlen   = m1_awlen;
        io_master_awsize  = m1_awsize;
        io_master_awburst = m1_awburst;
        m1_awready        = io_master_awready & ~aw_done_q;
        io_master_wvalid  = m1_wvalid & ~w_done_q;
        io_master_wdata   = m1_wdata;
        io_master_wstrb   = m1_wstrb;
        io_master_wlast   = m1_wlast;
        m1_wready         = io_master_wready & ~w_done_q;
        m1_bvalid         = io_master_bvalid;
        m1_bresp          = io_master_bresp;
        m1_bid            = io_master_bid;
        io_master_bready  = m1_bready;
        if (m1_awvalid && !aw_done_q && io_master_awready) begin
          aw_done_d = 1'b1;
        end
        if (m1_wvalid && m1_wlast && !w_done_q && io_master_wready) begin
          w_done_d = 1'b1;
        end
        if (io_master_bvalid && m1_bready) begin
          state_d   = ARB_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
